// File: rtl/ethernet_pkg.sv
// ethernet_pkg
//   Shared types for the receive-clock speed detector:
//     link_speed_t    - encoded link speed (10M / 100M / 1G)
//     lsd_state_t     - link_speed_detect FSM states
//     classify_period - maps a measured rxc/8 period (in clk_125 cycles)
//                       onto a link speed using two thresholds
package ethernet_pkg;

  typedef enum logic [1:0] {
    SPEED_10M  = 2'b00,
    SPEED_100M = 2'b01,
    SPEED_1G   = 2'b10
  } link_speed_t;

  typedef enum logic [1:0] {
    S_NOCLK   = 2'b00,
    S_ACQUIRE = 2'b01,
    S_LOCKED  = 2'b10
  } lsd_state_t;

  localparam int CHG_CNT_W = 16;

  // Short periods mean fast receive clocks.
  function automatic link_speed_t classify_period(input int period,
                                                  input int thresh_1g,
                                                  input int thresh_100m);
    link_speed_t cls;
    if (period < thresh_1g)
      cls = SPEED_1G;
    else if (period < thresh_100m)
      cls = SPEED_100M;
    else
      cls = SPEED_10M;
    return cls;
  endfunction

endpackage

// File: rtl/lsd_sync_edge.sv
// lsd_sync_edge
//   Brings the asynchronous divided receive clock into the clk_125 domain
//   and flags its rising edges.
//   Ports:
//     clk_125     - system clock (rising edge)
//     reset_n     - asynchronous active-low reset
//     rxc_div_tgl - asynchronous rxc/8 toggle
//     rise_pulse  - one-cycle pulse, SYNC_STAGES+1 cycles after a rising
//                   edge of rxc_div_tgl
module lsd_sync_edge
  import ethernet_pkg::*;
#(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk_125,
  input  logic reset_n,
  input  logic rxc_div_tgl,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // The edge pulse is registered so downstream logic sees a clean
  // flop output; this is the "+1" in the edge-to-detect latency.
  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      last_q     <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rxc_div_tgl};
      last_q     <= sync_q[SYNC_STAGES-1];
      rise_pulse <= sync_q[SYNC_STAGES-1] & ~last_q;
    end
  end

endmodule

// File: rtl/link_speed_detect.sv
// link_speed_detect
//   Measures the period of the rxc/8 toggle in clk_125 cycles and derives
//   the Ethernet link speed with hysteresis and loss-of-clock detection.
//   Ports:
//     clk_125     - single clock, rising edge
//     reset_n     - asynchronous active-low reset
//     rxc_div_tgl - asynchronous rxc/8 toggle
//     link_speed  - 00 = 10M, 01 = 100M, 10 = 1G (reset value 10)
//     link_valid  - a locked speed is present
//     mii_sel     - 1 when link_speed is not 1G
//     speed_chg   - one-cycle pulse when link_speed changes value
//   Optional (macro LINK_SPEED_STATS_EN):
//     chg_cnt     - saturating count of speed_chg pulses
//     last_period - most recent measured period
module link_speed_detect
  import ethernet_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int THRESH_1G      = 20,
  parameter int THRESH_100M    = 200,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int STABLE_COUNT   = 4
) (
  input  logic       clk_125,
  input  logic       reset_n,
  input  logic       rxc_div_tgl,
  output logic [1:0] link_speed,
  output logic       link_valid,
  output logic       mii_sel,
  output logic       speed_chg
`ifdef LINK_SPEED_STATS_EN
  ,
  output logic [CHG_CNT_W-1:0]                   chg_cnt,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]    last_period
`endif
);

  localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int MATCH_W = $clog2(STABLE_COUNT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(STABLE_COUNT);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("link_speed_detect: SYNC_STAGES must be at least 2");
  end
  if (!(THRESH_1G > 0 && THRESH_1G < THRESH_100M &&
        THRESH_100M < TIMEOUT_CYCLES && STABLE_COUNT >= 1)) begin : g_bad_param
    $error("link_speed_detect: need 0 < THRESH_1G < THRESH_100M < TIMEOUT_CYCLES and STABLE_COUNT >= 1");
  end

  logic               rise;
  lsd_state_t         state;
  logic [CNT_W-1:0]   period_cnt;
  link_speed_t        candidate;
  logic [MATCH_W-1:0] match_cnt;
  link_speed_t        speed_q;

  link_speed_t        meas_cls;
  link_speed_t        cand_nxt;
  logic [MATCH_W-1:0] match_nxt;
  logic               meas_en;
  logic               lock_now;
  logic               timeout;

  lsd_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_125     (clk_125),
    .reset_n     (reset_n),
    .rxc_div_tgl (rxc_div_tgl),
    .rise_pulse  (rise)
  );

  always_comb begin
    meas_cls  = classify_period(32'(period_cnt), THRESH_1G, THRESH_100M);
    // The first edge out of S_NOCLK only starts the counter.
    meas_en   = rise && (state != S_NOCLK);
    cand_nxt  = candidate;
    match_nxt = match_cnt;
    if (meas_cls == candidate) begin
      if (match_cnt != MATCH_MAX)
        match_nxt = match_cnt + 1'b1;
    end else begin
      cand_nxt  = meas_cls;
      match_nxt = MATCH_W'(1);
    end
    lock_now  = meas_en && (match_nxt == MATCH_MAX);
    // A coincident edge wins over the timeout and is measured instead.
    timeout   = !rise && (period_cnt == CNT_MAX);
  end

  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_NOCLK;
      period_cnt <= '0;
      candidate  <= SPEED_10M;
      match_cnt  <= '0;
      speed_q    <= SPEED_1G;
      link_valid <= 1'b0;
      mii_sel    <= 1'b0;
      speed_chg  <= 1'b0;
    end else begin
      speed_chg <= 1'b0;

      if (rise)
        period_cnt <= CNT_W'(1);
      else if (period_cnt != CNT_MAX)
        period_cnt <= period_cnt + 1'b1;

      case (state)
        S_NOCLK: begin
          if (rise)
            state <= S_ACQUIRE;
        end
        S_ACQUIRE, S_LOCKED: begin
          if (meas_en) begin
            candidate <= cand_nxt;
            match_cnt <= match_nxt;
            // While locked, the same speed keeps being rewritten once the
            // match counter saturates; only a real change pulses speed_chg.
            if (lock_now) begin
              state      <= S_LOCKED;
              link_valid <= 1'b1;
              speed_q    <= cand_nxt;
              mii_sel    <= (cand_nxt != SPEED_1G);
              speed_chg  <= (cand_nxt != speed_q);
            end
          end else if (timeout) begin
            state      <= S_NOCLK;
            link_valid <= 1'b0;
            match_cnt  <= '0;
          end
        end
        default: state <= S_NOCLK;
      endcase
    end
  end

  assign link_speed = speed_q;

`ifdef LINK_SPEED_STATS_EN
  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n) begin
      chg_cnt     <= '0;
      last_period <= '0;
    end else begin
      if (meas_en)
        last_period <= period_cnt;
      if (speed_chg && (chg_cnt != {CHG_CNT_W{1'b1}}))
        chg_cnt <= chg_cnt + 1'b1;
    end
  end
`endif

endmodule
